// File: rtl/bitcoin_hash_sequencer.sv
// Sequencer that walks one SHA-256 core through the Bitcoin double-hash schedule
// for nonces 0..NUM_NONCES-1, feeding header reads and storing one hash word per nonce.
//
// state       | meaning
// S_IDLE      | waiting for start, strobes low
// S_NONCE_INIT| pulse core_start for the current nonce
// S_READ1A    | read header word 0
// S_READ2     | read header word 1
// S_COMPUTE1  | read header word 2
// S_BLOCK1    | first block, reads words 3..15 then holds address
// S_COMPUTE2A | first compress after BLOCK1
// S_READ1B    | read header word 16
// S_BLOCK2    | second block, reads words 17..18 then holds address
// S_COMPUTE2B | compress after BLOCK2
// S_BLOCK3    | second hash pass, no memory traffic
// S_COMPUTE2C | final compress
// S_WRITE     | store core_hash at output_addr + nonce
// S_DONE      | one cycle with done raised before returning idle
module bitcoin_hash_sequencer #(
    parameter int NUM_NONCES   = 16,
    parameter int BLOCK_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [15:0] message_addr_i,
    input  logic [15:0] output_addr_i,
    output logic        done_o,
    output logic        mem_clk_en_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [31:0] mem_write_data_o,
    output logic        core_start_o,
    output logic [3:0]  core_state_o,
    output logic [31:0] core_nonce_o,
    input  logic [31:0] core_hash_i
);

    localparam int CW = ($clog2(BLOCK_CYCLES) < 4) ? 4 : $clog2(BLOCK_CYCLES);
    localparam logic [CW-1:0] CYC_LAST   = CW'(BLOCK_CYCLES - 1);
    localparam logic [15:0]   LAST_NONCE = 16'(NUM_NONCES - 1);

    localparam logic [3:0] CORE_IDLE     = 4'd0;
    localparam logic [3:0] CORE_READ1    = 4'd1;
    localparam logic [3:0] CORE_READ2    = 4'd2;
    localparam logic [3:0] CORE_BLOCK1   = 4'd3;
    localparam logic [3:0] CORE_BLOCK2   = 4'd4;
    localparam logic [3:0] CORE_BLOCK3   = 4'd5;
    localparam logic [3:0] CORE_COMPUTE1 = 4'd6;
    localparam logic [3:0] CORE_COMPUTE2 = 4'd7;
    localparam logic [3:0] CORE_WRITE    = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NONCE_INIT,
        S_READ1A,
        S_READ2,
        S_COMPUTE1,
        S_BLOCK1,
        S_COMPUTE2A,
        S_READ1B,
        S_BLOCK2,
        S_COMPUTE2B,
        S_BLOCK3,
        S_COMPUTE2C,
        S_WRITE,
        S_DONE
    } seq_state_e;

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [15:0]   nonce_q, nonce_d;
    logic [15:0]   msg_base_q, msg_base_d;
    logic [15:0]   out_base_q, out_base_d;
    logic          done_q, done_d;
    logic          cyc_last;

    assign cyc_last     = (cyc_q == CYC_LAST);
    assign done_o       = done_q;
    assign core_nonce_o = {16'h0000, nonce_q};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            nonce_q    <= '0;
            msg_base_q <= '0;
            out_base_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            nonce_q    <= nonce_d;
            msg_base_q <= msg_base_d;
            out_base_q <= out_base_d;
            done_q     <= done_d;
        end
    end

    // Memory strobes are decoded from registered state so a reset assertion
    // kills an in-flight write immediately.
    always_comb begin
        state_d          = state_q;
        cyc_d            = cyc_q;
        nonce_d          = nonce_q;
        msg_base_d       = msg_base_q;
        out_base_d       = out_base_q;
        done_d           = done_q;
        core_state_o     = CORE_IDLE;
        core_start_o     = 1'b0;
        mem_clk_en_o     = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = 16'h0000;
        mem_write_data_o = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    msg_base_d = message_addr_i;
                    out_base_d = output_addr_i;
                    nonce_d    = 16'h0000;
                    done_d     = 1'b0;
                    state_d    = S_NONCE_INIT;
                end
            end
            S_NONCE_INIT: begin
                core_start_o = 1'b1;
                state_d      = S_READ1A;
            end
            S_READ1A: begin
                core_state_o = CORE_READ1;
                mem_clk_en_o = 1'b1;
                mem_addr_o   = msg_base_q;
                state_d      = S_READ2;
            end
            S_READ2: begin
                core_state_o = CORE_READ2;
                mem_clk_en_o = 1'b1;
                mem_addr_o   = msg_base_q + 16'd1;
                state_d      = S_COMPUTE1;
            end
            S_COMPUTE1: begin
                core_state_o = CORE_COMPUTE1;
                mem_clk_en_o = 1'b1;
                mem_addr_o   = msg_base_q + 16'd2;
                cyc_d        = '0;
                state_d      = S_BLOCK1;
            end
            S_BLOCK1: begin
                core_state_o = CORE_BLOCK1;
                if (cyc_q <= CW'(12)) begin
                    mem_clk_en_o = 1'b1;
                    mem_addr_o   = msg_base_q + 16'd3 + 16'(cyc_q);
                end else begin
                    mem_addr_o   = msg_base_q + 16'd15;
                end
                cyc_d = cyc_q + CW'(1);
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_COMPUTE2A;
                end
            end
            S_COMPUTE2A: begin
                core_state_o = CORE_COMPUTE2;
                state_d      = S_READ1B;
            end
            S_READ1B: begin
                core_state_o = CORE_READ1;
                mem_clk_en_o = 1'b1;
                mem_addr_o   = msg_base_q + 16'd16;
                cyc_d        = '0;
                state_d      = S_BLOCK2;
            end
            S_BLOCK2: begin
                core_state_o = CORE_BLOCK2;
                if (cyc_q == CW'(0)) begin
                    mem_clk_en_o = 1'b1;
                    mem_addr_o   = msg_base_q + 16'd17;
                end else begin
                    mem_clk_en_o = (cyc_q == CW'(1));
                    mem_addr_o   = msg_base_q + 16'd18;
                end
                cyc_d = cyc_q + CW'(1);
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_COMPUTE2B;
                end
            end
            S_COMPUTE2B: begin
                core_state_o = CORE_COMPUTE2;
                cyc_d        = '0;
                state_d      = S_BLOCK3;
            end
            S_BLOCK3: begin
                core_state_o = CORE_BLOCK3;
                cyc_d        = cyc_q + CW'(1);
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_COMPUTE2C;
                end
            end
            S_COMPUTE2C: begin
                core_state_o = CORE_COMPUTE2;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                core_state_o     = CORE_WRITE;
                mem_clk_en_o     = 1'b1;
                mem_we_o         = 1'b1;
                mem_addr_o       = out_base_q + nonce_q;
                mem_write_data_o = core_hash_i;
                if (nonce_q == LAST_NONCE) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    nonce_d = nonce_q + 16'd1;
                    state_d = S_NONCE_INIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bitcoin_hash_sequencer.sv
// Self-checking bench: every cycle of each run is compared against a schedule table
// built from the per-nonce step list, plus a write scoreboard and done timing.
module tb_bitcoin_hash_sequencer;

    localparam int NN   = 16;
    localparam int BC   = 64;
    localparam int PER  = 201;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        done;
    logic        mem_clk_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        core_start;
    logic [3:0]  core_state;
    logic [31:0] core_nonce;
    logic [31:0] core_hash;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0]  tab_cs   [0:PER-1];
    logic        tab_st   [0:PER-1];
    logic        tab_en   [0:PER-1];
    logic        tab_we   [0:PER-1];
    int          tab_word [0:PER-1];
    int          tab_n;

    logic [15:0] msg_b;
    logic [15:0] out_b;
    logic [31:0] hkey;
    logic [31:0] wmem [int];
    int          wcount;
    int          reads0;
    int          first_done;

    // Behavioural SHA core stand-in: hash word is a run key plus the nonce.
    assign core_hash = hkey + core_nonce;

    bitcoin_hash_sequencer #(.NUM_NONCES(NN), .BLOCK_CYCLES(BC)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .start_i          (start),
        .message_addr_i   (message_addr),
        .output_addr_i    (output_addr),
        .done_o           (done),
        .mem_clk_en_o     (mem_clk_en),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_write_data_o (mem_write_data),
        .core_start_o     (core_start),
        .core_state_o     (core_state),
        .core_nonce_o     (core_nonce),
        .core_hash_i      (core_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] cs, input logic st, input logic en, input logic we, input int word);
        tab_cs[tab_n]   = cs;
        tab_st[tab_n]   = st;
        tab_en[tab_n]   = en;
        tab_we[tab_n]   = we;
        tab_word[tab_n] = word;
        tab_n++;
    endtask

    task automatic build_table();
        tab_n = 0;
        push(4'd0, 1'b1, 1'b0, 1'b0, 0);
        push(4'd1, 1'b0, 1'b1, 1'b0, 0);
        push(4'd2, 1'b0, 1'b1, 1'b0, 1);
        push(4'd6, 1'b0, 1'b1, 1'b0, 2);
        for (int c = 0; c < BC; c++) push(4'd3, 1'b0, (c <= 12), 1'b0, 3 + c);
        push(4'd7, 1'b0, 1'b0, 1'b0, 0);
        push(4'd1, 1'b0, 1'b1, 1'b0, 16);
        for (int c = 0; c < BC; c++) push(4'd4, 1'b0, (c <= 1), 1'b0, 17 + c);
        push(4'd7, 1'b0, 1'b0, 1'b0, 0);
        for (int c = 0; c < BC; c++) push(4'd5, 1'b0, 1'b0, 1'b0, 0);
        push(4'd7, 1'b0, 1'b0, 1'b0, 0);
        push(4'd8, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic check_quiet(input string tag, input int t);
        chk({tag, "_state"}, t, 32'(core_state), 32'd0);
        chk({tag, "_we"},    t, 32'(mem_we),     32'd0);
        chk({tag, "_en"},    t, 32'(mem_clk_en), 32'd0);
        chk({tag, "_start"}, t, 32'(core_start), 32'd0);
        chk({tag, "_done"},  t, 32'(done),       32'd0);
    endtask

    task automatic check_cycle(input int t);
        int          n, k;
        logic [15:0] eaddr;
        if (t <= PER * NN) begin
            n = (t - 1) / PER;
            k = (t - 1) % PER;
            chk("core_state", t, 32'(core_state), 32'(tab_cs[k]));
            chk("core_start", t, 32'(core_start), 32'(tab_st[k]));
            chk("mem_clk_en", t, 32'(mem_clk_en), 32'(tab_en[k]));
            chk("mem_we",     t, 32'(mem_we),     32'(tab_we[k]));
            chk("done_run",   t, 32'(done),       32'd0);
            chk("core_nonce", t, core_nonce,      32'(n));
            if (tab_en[k]) begin
                eaddr = tab_we[k] ? 16'(out_b + 16'(n)) : 16'(msg_b + 16'(tab_word[k]));
                chk("mem_addr", t, 32'(mem_addr), 32'(eaddr));
            end
            if (tab_we[k]) chk("wdata", t, mem_write_data, hkey + 32'(n));
        end else begin
            chk("end_state", t, 32'(core_state), 32'd0);
            chk("end_en",    t, 32'(mem_clk_en), 32'd0);
            chk("end_we",    t, 32'(mem_we),     32'd0);
            chk("end_done",  t, 32'(done),       32'd1);
        end
    endtask

    task automatic do_run(input logic [15:0] msg, input logic [15:0] outb, input logic [31:0] key,
                          input int stray_t, input int abort_t);
        int   total;
        logic aborted;
        logic [15:0] a;
        msg_b      = msg;
        out_b      = outb;
        hkey       = key;
        wmem.delete();
        wcount     = 0;
        reads0     = 0;
        first_done = -1;
        aborted    = 1'b0;
        total      = PER * NN + 2;
        @(negedge clk);
        message_addr = msg;
        output_addr  = outb;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        message_addr = 16'($urandom);
        output_addr  = 16'($urandom);
        for (int t = 1; t <= total; t++) begin
            if (t > 1) @(negedge clk);
            check_cycle(t);
            if (mem_clk_en === 1'b1 && mem_we === 1'b1) begin
                wmem[int'(mem_addr)] = mem_write_data;
                wcount++;
            end
            if (t <= PER && mem_clk_en === 1'b1 && mem_we === 1'b0) begin
                chk("read_order", t, 32'(mem_addr), 32'(16'(msg_b + 16'(reads0))));
                reads0++;
            end
            if (done === 1'b1 && first_done < 0) first_done = t;
            start = (t == stray_t);
            if (t == stray_t) begin
                message_addr = 16'($urandom);
                output_addr  = 16'($urandom);
            end
            if (t == abort_t) begin
                start   = 1'b0;
                reset_n = 1'b0;
                #1;
                check_quiet("abort_async", t);
                @(posedge clk);
                #1;
                check_quiet("abort_edge", t);
                @(negedge clk);
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (aborted) begin
            chk("abort_writes", abort_t, 32'(wcount), 32'((abort_t - 1) / PER));
            a = 16'(outb + 16'((abort_t - 1) / PER));
            chk("abort_no_write", abort_t, 32'(wmem.exists(int'(a))), 32'd0);
            @(negedge clk);
            check_quiet("abort_idle", abort_t);
        end else begin
            chk("done_rise", 0, 32'(first_done), 32'(PER * NN + 1));
            chk("write_count", 0, 32'(wcount), 32'(NN));
            chk("reads_nonce0", 0, 32'(reads0), 32'd19);
            for (int n = 0; n < NN; n++) begin
                a = 16'(outb + 16'(n));
                chk("sb_present", n, 32'(wmem.exists(int'(a))), 32'd1);
                if (wmem.exists(int'(a))) chk("sb_data", n, wmem[int'(a)], key + 32'(n));
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        message_addr = 16'h0000;
        output_addr  = 16'h0000;
        hkey         = 32'hA5A5_0000;
        build_table();

        repeat (3) @(negedge clk);
        check_quiet("reset", 0);
        chk("reset_addr",  0, 32'(mem_addr),     32'd0);
        chk("reset_wdata", 0, mem_write_data,    32'd0);
        chk("reset_nonce", 0, core_nonce,        32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("idle", 0);

        // Baseline run with a stray start pulse at cycle 50.
        do_run(16'h0000, 16'h00E0, 32'hA5A5_0000, 50, 0);

        // Abort in BLOCK2 of nonce 3 (offset 80 in that nonce's schedule).
        do_run(16'($urandom), 16'($urandom), $urandom, 0, 3 * PER + 81);

        // Fresh start after the abort must restart from nonce 0.
        do_run(16'($urandom), 16'h00E0, 32'hA5A5_0000, 0, 0);

        // Both base addresses wrap past 0xFFFF.
        do_run(16'hFFF0, 16'hFFF8, 32'hA5A5_0000, 0, 0);
        chk("wrap_n8",  8,  wmem.exists(0) ? wmem[0] : 32'hDEAD_BEEF, 32'hA5A5_0008);
        chk("wrap_n15", 15, wmem.exists(7) ? wmem[7] : 32'hDEAD_BEEF, 32'hA5A5_000F);

        // Fully random run with a stray start somewhere mid-run.
        do_run(16'($urandom), 16'($urandom), $urandom, int'($urandom_range(2, 3000)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bitcoin_hash_sequencer.md
Name: bitcoin_hash_sequencer

Overview:
Top-level control FSM that drives one simplified_sha256 core through the full Bitcoin double-hash schedule for a range of nonces.
- Issues the core's 4-bit state code, nonce and core start pulse.
- Generates memory read addresses for the 19-word header, with single-cycle-latency memory.
- Writes each returned 32-bit hash word to output memory at output_addr + nonce.
- Sits between the testbench memory interface and the SHA core; it is the memory-side master/writer that pairs with the core's read-only data path.

Parameters:
NUM_NONCES, 16, number of nonces processed per start (0..NUM_NONCES-1); range 1..65535
BLOCK_CYCLES, 64, cycles spent in each of BLOCK1/BLOCK2/BLOCK3

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only when idle
message_addr  input  16  base address of header words 0..18
output_addr  input  16  base address of result array
done  output  1  high when the run is complete; held until next accepted start
mem_clk_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  16  memory address
mem_write_data  output  32  memory write data
core_start  output  1  start pulse to SHA core
core_state  output  4  state code to core: IDLE=0, READ1=1, READ2=2, BLOCK1=3, BLOCK2=4, BLOCK3=5, COMPUTE1=6, COMPUTE2=7, WRITE=8
core_nonce  output  32  current nonce, zero-extended counter
core_hash  input  32  hash word from core, valid in WRITE

Behaviour:
- Reset (async, active-low):
  - core_state=IDLE; done=0; mem_clk_en=0; mem_we=0; mem_addr=0; mem_write_data=0; core_start=0.
  - Nonce counter=0; cycle counter=0.
  - Reset mid-run aborts immediately; no partial write completes after reset assertion.
- Idle:
  - core_state=IDLE, all memory strobes low.
  - On start=1: latch message_addr/output_addr, nonce=0, done<=0, go to NONCE_INIT.
  - start while not idle is ignored; address inputs are only sampled at an accepted start.
- Per-nonce schedule, one cycle per step unless stated:
  1. NONCE_INIT: core_state=IDLE, core_start=1.
  2. READ1: mem_addr=base+0.
  3. READ2: base+1.
  4. COMPUTE1: base+2.
  5. BLOCK1 for BLOCK_CYCLES cycles, cycle counter c=0..63: mem_addr=base+3+c while c<=12; address held afterwards.
  6. COMPUTE2.
  7. READ1: base+16.
  8. BLOCK2 for 64 cycles: cycle 0 mem_addr=base+17, cycle 1 base+18, then held.
  9. COMPUTE2.
  10. BLOCK3 for 64 cycles, no memory access.
  11. COMPUTE2.
  12. WRITE: mem_we=1, mem_addr=output_addr+nonce (mod 2^16), mem_write_data=core_hash.
- Strobes and counters:
  - mem_clk_en=1 in every cycle that issues a read or write; 0 otherwise.
  - mem_we=1 only in WRITE.
  - Cycle counter resets to 0 on entry to each BLOCK state.
- After WRITE:
  - If nonce==NUM_NONCES-1: go to DONE (core_state=IDLE, done=1), then return to idle on the next cycle with done still held at 1.
  - Otherwise nonce++ and go to NONCE_INIT.
- Timing:
  - Per-nonce latency from NONCE_INIT to WRITE inclusive is 201 cycles.
  - Total run is 201*NUM_NONCES+1 cycles from accepted start to done rising.
- Other rules:
  - core_nonce is stable for the whole schedule of a nonce and changes only on the NONCE_INIT transition.
  - All address arithmetic is 16-bit and wraps; base+18 and output_addr+nonce overflow wrap to low addresses.
  - done clears on the cycle after an accepted start.

Test Plan:
- Reset then start with message_addr=0, output_addr=16'h00E0, NUM_NONCES=16 -> 16 writes to 0x00E0..0x00EF in nonce order; done rises at cycle 3217 after start.
- Monitor read addresses for nonce 0 -> exactly words 0..18 in order, each once; read N issued in the cycle mapped above; no reads during BLOCK3.
- Core model returns core_hash=32'hA5A50000+nonce in WRITE -> mem_write_data at address 0x00E0+n equals 32'hA5A50000+n.
- Pulse start at cycle 50 of a run -> ignored: schedule, addresses and done timing unchanged.
- Deassert reset_n during BLOCK2 of nonce 3 -> next edge core_state=0, mem_we=0, done=0; no write for nonce 3; a fresh start restarts at nonce 0.
- output_addr=16'hFFF8, NUM_NONCES=16 -> writes wrap: nonce 8 written at 0x0000, nonce 15 written at 0x0007.
